core_loader: RTL

CORE_LOADER -- requirements
Module: core_loader

---
 rtl/core_loader_pkg.sv | 18 +
 rtl/loader_word_pack.sv | 49 ++++
 rtl/core_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/core_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Imported by the loader FSM and its byte-packing helper.
package core_loader_pkg;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/loader_word_pack.sv
// Little-endian byte-to-word packer: the first byte
// shifted in ends up in bits 7:0 of the word.
module loader_word_pack
  import core_loader_pkg::*;
#(
  parameter int MEM_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 byte_en_i,
  input  logic [7:0]           byte_i,
  output logic [MEM_WIDTH-1:0] word_o,
  output logic                 word_full_o
);

  localparam int LW = $clog2(BYTES_PER_WORD);
  localparam logic [LW-1:0] LAST = LW'(BYTES_PER_WORD - 1);

  logic [LW-1:0]        lane_q, lane_d;
  logic [MEM_WIDTH-1:0] sh_q, sh_d;

  // High when the byte being accepted completes a word.
  assign word_full_o = byte_en_i && (lane_q == LAST);
  assign word_o      = sh_q;

  always_comb begin
    lane_d = lane_q;
    sh_d   = sh_q;
    if (clear_i) begin
      lane_d = '0;
      sh_d   = '0;
    end else if (byte_en_i) begin
      lane_d = lane_q + 1'b1;
      sh_d   = {byte_i, sh_q[MEM_WIDTH-1:8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      sh_q   <= '0;
    end else begin
      lane_q <= lane_d;
      sh_q   <= sh_d;
    end
  end

endmodule

// File: rtl/core_loader.sv
// Streams a length-prefixed program into instruction
// memory and holds the core in reset until it is loaded.
module core_loader
  import core_loader_pkg::*;
#(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic [31:0]          mem_addr,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          word_cnt
);

  localparam logic [HDR_W:0] MAX_N = (HDR_W+1)'(MEM_SIZE);

  state_e           state_q, state_d;
  logic [HDR_W-1:0] n_q, n_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             xfer, pack_clr, pack_en, word_full;

  assign xfer    = byte_valid && byte_ready;
  assign pack_en = xfer && (state_q == S_DATA);

  loader_word_pack #(
    .MEM_WIDTH(MEM_WIDTH)
  ) u_pack (
    .clk        (clk),
    .rst_n      (reset),
    .clear_i    (pack_clr),
    .byte_en_i  (pack_en),
    .byte_i     (byte_data),
    .word_o     (mem_write_val),
    .word_full_o(word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    pack_clr   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          word_cnt_d = '0;
          pack_clr   = 1'b1;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          n_d[7:0] = byte_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d[15:8] = byte_data;
          if (n_d == '0)
            state_d = S_DONE;
          else if ({1'b0, n_d} > MAX_N)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = (word_cnt_d == n_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready   = 1'b0;
    mem_write_en = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    core_reset   = 1'b1;
    unique case (state_q)
      S_HDR0, S_HDR1, S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        mem_write_en = 1'b1;
        busy         = 1'b1;
      end
      S_DONE: begin
        done       = 1'b1;
        core_reset = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  assign word_cnt = word_cnt_q;
  assign mem_addr = {14'd0, word_cnt_q, 2'b00};

endmodule
